proj_datapath: RTL and testbench

Parametrised register-file datapath with a serial instruction port. It replaces the fixed three-register A/B/C + D arrangement with NREGS general registers of WIDTH bits, an 8-operation ALU with zero/carry flags, and a stall-tolerant serial instruction shifter. Instructions arrive one bit per clock on `instr_in`, then execute in a single cycle with a one-cycle `done` pulse. Register contents and the output accumulator are exported flat so that per-digit 7-segment decoders can sit outside the block.

---
 rtl/proj_datapath_pkg.sv | 22 ++
 rtl/proj_alu.sv | 42 ++++
 rtl/proj_datapath.sv | 138 +++++++++++++
 tb/tb_proj_datapath.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/proj_datapath_pkg.sv
// Shared opcode values and FSM state encoding for the register-file datapath.
package proj_datapath_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_LOAD = 3'd0;
    localparam logic [OP_W-1:0] OP_ADD  = 3'd1;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd2;
    localparam logic [OP_W-1:0] OP_AND  = 3'd3;
    localparam logic [OP_W-1:0] OP_OR   = 3'd4;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd5;
    localparam logic [OP_W-1:0] OP_NOT  = 3'd6;
    localparam logic [OP_W-1:0] OP_OUT  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/proj_alu.sv
// Combinational 8-operation ALU; a is the destination operand, b the source
// operand (or the external load value, selected by the caller).
module proj_alu
    import proj_datapath_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] w_sum;

    assign w_sum = {1'b0, a} + {1'b0, b};

    // Operation select; carry is only meaningful for ADD (carry) and SUB (borrow)
    always_comb begin
        result = b;
        carry  = 1'b0;
        case (op)
            OP_LOAD: result = b;
            OP_ADD: begin
                result = w_sum[WIDTH-1:0];
                carry  = w_sum[WIDTH];
            end
            OP_SUB: begin
                result = a - b;
                carry  = (b > a);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~b;
            OP_OUT:  result = b;
            default: result = b;
        endcase
    end

endmodule

// File: rtl/proj_datapath.sv
// Register-file datapath: serial instruction shifter, FSM, register file,
// output accumulator and flags around a single-cycle ALU.
module proj_datapath
    import proj_datapath_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NREGS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   instr_in,
    input  logic                   instr_valid,
    input  logic [WIDTH-1:0]       data_in,
    output logic                   busy,
    output logic                   done,
    output logic [NREGS*WIDTH-1:0] reg_out,
    output logic [WIDTH-1:0]       acc_out,
    output logic                   flag_z,
    output logic                   flag_c
);

    localparam int unsigned RIW  = $clog2(NREGS);
    localparam int unsigned ILEN = OP_W + 2 * RIW;
    localparam int unsigned CW   = $clog2(ILEN + 1);

    state_t           r_state;
    logic [ILEN-1:0]  r_shift;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_regs [NREGS];
    logic [WIDTH-1:0] r_acc;
    logic             r_z;
    logic             r_c;
    logic             r_busy;
    logic             r_done;

    logic [OP_W-1:0]  w_op;
    logic [RIW-1:0]   w_dst;
    logic [RIW-1:0]   w_src;
    logic             w_dst_ok;
    logic             w_src_ok;
    logic [WIDTH-1:0] w_dst_val;
    logic [WIDTH-1:0] w_src_val;
    logic [WIDTH-1:0] w_alu_b;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;

    // Instruction fields, MSB-first word {op, dst, src}
    assign w_op  = r_shift[ILEN-1 -: OP_W];
    assign w_dst = r_shift[2*RIW-1 -: RIW];
    assign w_src = r_shift[RIW-1:0];

    // Out-of-range indices read as zero and suppress the write
    assign w_dst_ok  = (32'(w_dst) < NREGS);
    assign w_src_ok  = (32'(w_src) < NREGS);
    assign w_dst_val = w_dst_ok ? r_regs[w_dst] : '0;
    assign w_src_val = w_src_ok ? r_regs[w_src] : '0;
    assign w_alu_b   = (w_op == OP_LOAD) ? data_in : w_src_val;

    proj_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (w_dst_val),
        .b      (w_alu_b),
        .op     (w_op),
        .result (w_result),
        .carry  (w_carry)
    );

    // Sequencer: shift bits in, execute once, pulse done, return to idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_count <= '0;
            r_acc   <= '0;
            r_z     <= 1'b0;
            r_c     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        r_shift <= {r_shift[ILEN-2:0], instr_in};
                        r_count <= CW'(1);
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (instr_valid) begin
                        r_shift <= {r_shift[ILEN-2:0], instr_in};
                        r_count <= r_count + CW'(1);
                        if (r_count == CW'(ILEN - 1)) begin
                            r_state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (w_op == OP_OUT) begin
                        r_acc <= w_result;
                    end else begin
                        if (w_dst_ok) begin
                            r_regs[w_dst] <= w_result;
                        end
                        r_z <= (w_result == '0);
                        r_c <= w_carry;
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Flatten the register file for external display decoders
    for (genvar g = 0; g < int'(NREGS); g++) begin : g_flat
        assign reg_out[g*WIDTH +: WIDTH] = r_regs[g];
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign acc_out = r_acc;
    assign flag_z  = r_z;
    assign flag_c  = r_c;

endmodule

// File: tb/tb_proj_datapath.sv
// Self-checking bench for proj_datapath (WIDTH=4, NREGS=4, ILEN=7) against an
// arithmetic reference model of the instruction set.
module tb_proj_datapath;

    localparam int WIDTH = 4;
    localparam int NREGS = 4;
    localparam int ILEN  = 7;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic                   clk;
    logic                   rst;
    logic                   instr_in;
    logic                   instr_valid;
    logic [WIDTH-1:0]       data_in;
    logic                   busy;
    logic                   done;
    logic [NREGS*WIDTH-1:0] reg_out;
    logic [WIDTH-1:0]       acc_out;
    logic                   flag_z;
    logic                   flag_c;

    int n_checks;
    int n_fail;

    int m_regs [NREGS];
    int m_acc;
    int m_z;
    int m_c;

    proj_datapath #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .data_in     (data_in),
        .busy        (busy),
        .done        (done),
        .reg_out     (reg_out),
        .acc_out     (acc_out),
        .flag_z      (flag_z),
        .flag_c      (flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NREGS; i++) m_regs[i] = 0;
        m_acc = 0;
        m_z   = 0;
        m_c   = 0;
    endfunction

    // Instruction semantics in plain integer arithmetic
    function automatic void model_exec(input int op, input int dst, input int src, input int data);
        int a;
        int b;
        int r;
        int c;
        a = m_regs[dst];
        b = m_regs[src];
        c = 0;
        case (op)
            0: r = data & MASK;
            1: begin r = (a + b) & MASK; c = ((a + b) > MASK) ? 1 : 0; end
            2: begin r = (a - b + (MASK + 1)) & MASK; c = (b > a) ? 1 : 0; end
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = MASK - b;
            default: r = 0;
        endcase
        if (op == 7) begin
            m_acc = b;
        end else begin
            m_regs[dst] = r;
            m_z = (r == 0) ? 1 : 0;
            m_c = c;
        end
    endfunction

    function automatic logic [31:0] model_flat();
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < NREGS; i++) f = f | (32'(m_regs[i]) << (i * WIDTH));
        return f;
    endfunction

    task automatic check_state(input string tag, input logic exp_busy, input logic exp_done);
        check_eq({tag, "_regs"}, 32'(reg_out), model_flat());
        check_eq({tag, "_acc"}, 32'(acc_out), 32'(m_acc));
        check_eq({tag, "_fz"}, 32'(flag_z), 32'(m_z));
        check_eq({tag, "_fc"}, 32'(flag_c), 32'(m_c));
        check_eq({tag, "_busy"}, 32'(busy), 32'(exp_busy));
        check_eq({tag, "_done"}, 32'(done), 32'(exp_done));
    endtask

    // Shift an instruction, optionally stalling before bit stall_at, then check the result
    task automatic run_instr(input string tag, input int op, input int dst, input int src,
                             input int data, input int stall_at, input int stall_len);
        logic [ILEN-1:0] word;
        int  edges;
        int  stalls;
        bit  seen;
        word    = {op[2:0], dst[1:0], src[1:0]};
        data_in = data[WIDTH-1:0];
        edges   = 0;
        stalls  = 0;
        for (int k = 0; k < ILEN; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    instr_valid = 1'b0;
                    instr_in    = 1'($urandom);
                    @(posedge clk); #1;
                    edges++;
                    stalls++;
                end
            end
            instr_valid = 1'b1;
            instr_in    = word[ILEN-1-k];
            @(posedge clk); #1;
            edges++;
            if (k == 0) check_eq({tag, "_busy_shift"}, 32'(busy), 32'(1));
        end
        instr_valid = 1'b0;
        instr_in    = 1'b0;
        model_exec(op, dst, src, data);
        seen = 1'b0;
        for (int w = 0; w < 20 && !seen; w++) begin
            @(posedge clk); #1;
            edges++;
            if (done) seen = 1'b1;
        end
        check_eq({tag, "_done_seen"}, 32'(seen), 32'(1));
        check_eq({tag, "_latency"}, 32'(edges), 32'(ILEN + 1 + stalls));
        check_state(tag, 1'b0, 1'b1);
        @(posedge clk); #1;
        check_eq({tag, "_done_width"}, 32'(done), 32'(0));
    endtask

    // Shift only the first nbits of an instruction, then reset between edges
    task automatic reset_mid(input string tag, input int op, input int dst, input int src,
                             input int data, input int nbits);
        logic [ILEN-1:0] word;
        word    = {op[2:0], dst[1:0], src[1:0]};
        data_in = data[WIDTH-1:0];
        for (int k = 0; k < nbits; k++) begin
            instr_valid = 1'b1;
            instr_in    = word[ILEN-1-k];
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_clear();
        check_state({tag, "_async"}, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_state({tag, "_after"}, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b0;
        instr_in    = 1'b0;
        instr_valid = 1'b0;
        data_in     = '0;
        model_clear();
        #3;
        check_state("por", 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Reset during shift, then a clean LOAD
        run_instr("pre_r3", 0, 3, 0, 6, -1, 0);
        reset_mid("rst_shift", 0, 3, 0, 9, 4);
        run_instr("load_r0", 0, 0, 0, 5, -1, 0);

        // LOAD latency and overflow ADD
        run_instr("load_r1", 0, 1, 0, 10, -1, 0);
        run_instr("load_r2", 0, 2, 0, 9, -1, 0);
        run_instr("add_ovf", 1, 1, 2, 0, -1, 0);

        // SUB to zero and SUB with borrow
        run_instr("sub_self", 2, 2, 2, 0, -1, 0);
        run_instr("load_r0b", 0, 0, 0, 2, -1, 0);
        run_instr("load_r3", 0, 3, 0, 5, -1, 0);
        run_instr("sub_borrow", 2, 0, 3, 0, -1, 0);

        // Stalled LOAD
        run_instr("load_stall", 0, 1, 0, 10, 3, 3);

        // OUT leaves flags intact; XOR self clears
        run_instr("out_r1", 7, 1, 1, 0, -1, 0);
        run_instr("xor_self", 5, 3, 3, 0, -1, 0);
        run_instr("not_r1", 6, 2, 1, 0, -1, 0);

        // Reset during ADD shift and during EXEC
        run_instr("pre_add", 0, 2, 0, 3, -1, 0);
        reset_mid("rst_add", 1, 2, 2, 0, 4);
        run_instr("pre_exec", 0, 1, 0, 12, -1, 0);
        reset_mid("rst_exec", 0, 1, 0, 7, 7);
        run_instr("load_post", 0, 2, 0, 7, -1, 0);

        // Random instruction stream with random stalls
        for (int n = 0; n < 60; n++) begin
            int op;
            int st;
            op = int'($urandom_range(0, 7));
            st = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, ILEN - 1)) : -1;
            run_instr($sformatf("rnd%0d", n), op, int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, MASK)),
                      st, int'($urandom_range(1, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
